// File: rtl/arb_pkg.sv
// Shared types and default sizing for the arbiter requester slice.
package arb_pkg;

    localparam int ARB_LEN_W   = 8;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_req_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Grant-wait counter: counts enabled cycles, raises a sticky flag on reaching TIMEOUT.
// Saturates at TIMEOUT so a long wait never wraps and re-arms the flag.
module arb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic flag_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flag_q;
    logic             flag_d;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clr_i) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: takes an N-beat job, requests the arbiter, issues one beat per
// granted cycle, tolerates grant withdrawal, and drops req after the last beat.
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W   = ARB_LEN_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat_en,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic [LEN_W-1:0] preempt_cnt,
    output logic             wait_timeout
);

    arb_req_state_t   state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] pcnt_q, pcnt_d;
    logic             first_q, first_d;
    logic             gnt_q;
    logic             timer_clr;
    logic             timer_en;

    assign job_ready = (state_q == ST_IDLE) && !reset;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        pcnt_d    = pcnt_q;
        first_d   = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        beat_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    len_d     = job_len;
                    idx_d     = '0;
                    pcnt_d    = '0;
                    timer_clr = 1'b1;
                    if (job_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                        first_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A grant seen in the first REQ cycle may be left over from the previous job.
                if (!first_q && gnt) begin
                    state_d = ST_XFER;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_XFER: begin
                if (gnt) begin
                    beat_en = 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (gnt_q && (pcnt_q != {LEN_W{1'b1}})) begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            pcnt_q  <= '0;
            first_q <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            first_q <= first_d;
            gnt_q   <= gnt;
        end
    end

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .flag_o (wait_timeout)
    );

    assign req         = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign done        = (state_q == ST_DONE);
    assign beat_idx    = idx_q;
    assign preempt_cnt = pcnt_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester; the bench plays the arbiter by driving gnt cycle by cycle.
module tb_arb_requester;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [7:0] job_len = 8'd0;
    logic       req;
    logic       gnt = 1'b0;
    logic       beat_en;
    logic [7:0] beat_idx;
    logic       done;
    logic [7:0] preempt_cnt;
    logic       wait_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    arb_requester #(
        .LEN_W   (8),
        .TIMEOUT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_len      (job_len),
        .req          (req),
        .gnt          (gnt),
        .beat_en      (beat_en),
        .beat_idx     (beat_idx),
        .done         (done),
        .preempt_cnt  (preempt_cnt),
        .wait_timeout (wait_timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, drive gnt mid-cycle and let outputs settle.
    task automatic cyc(input logic g);
        @(posedge clock);
        #2;
        gnt = g;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seq_err;

        // Reset values
        #12;
        check_eq("rst_req", req, 0);
        check_eq("rst_beat_en", beat_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wait_timeout", wait_timeout, 0);
        check_eq("rst_beat_idx", beat_idx, 0);
        check_eq("rst_preempt", preempt_cnt, 0);
        check_eq("rst_job_ready", job_ready, 0);
        cyc(0);
        reset = 1'b0;
        #1;
        check_eq("idle_job_ready", job_ready, 1);

        // Three-beat job, idle arbiter; grant lingers into DONE
        job_valid = 1'b1; job_len = 8'd3;
        cyc(0); job_valid = 1'b0;
        check_eq("l3_c1_req", req, 1);
        check_eq("l3_c1_ready", job_ready, 0);
        cyc(1);
        check_eq("l3_c2_beat_en", beat_en, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_eq("l3_beat_en", beat_en, 1);
            check_eq("l3_beat_idx", beat_idx, i);
        end
        cyc(1);
        check_eq("l3_done", done, 1);
        check_eq("l3_done_req", req, 0);
        check_eq("l3_done_beat_en", beat_en, 0);
        check_eq("l3_done_idx", beat_idx, 2);
        cyc(0);
        check_eq("l3_after_done", done, 0);
        check_eq("l3_ready_back", job_ready, 1);

        // Zero-length job
        job_valid = 1'b1; job_len = 8'd0;
        cyc(0); job_valid = 1'b0;
        check_eq("l0_done", done, 1);
        check_eq("l0_req", req, 0);
        cyc(0);
        check_eq("l0_done_gone", done, 0);
        check_eq("l0_req_idle", req, 0);
        check_eq("l0_ready", job_ready, 1);

        // Four-beat job preempted once after beat 1; job_valid held to confirm it is ignored
        job_valid = 1'b1; job_len = 8'd4;
        cyc(0); job_len = 8'd9;
        cyc(1);
        cyc(1); check_eq("pre_idx0", beat_idx, 0);
        cyc(1); check_eq("pre_idx1", beat_idx, 1);
        cyc(0);
        check_eq("pre_no_beat", beat_en, 0);
        check_eq("pre_req_held", req, 1);
        cyc(1);
        check_eq("pre_cnt", preempt_cnt, 1);
        check_eq("pre_resume_en", beat_en, 1);
        check_eq("pre_resume_idx", beat_idx, 2);
        cyc(1); check_eq("pre_idx3", beat_idx, 3);
        job_valid = 1'b0;
        cyc(0);
        check_eq("pre_done", done, 1);
        check_eq("pre_done_cnt", preempt_cnt, 1);
        cyc(0);

        // Grant-wait timeout (TIMEOUT=4) while another port holds the grant
        job_valid = 1'b1; job_len = 8'd2;
        cyc(0); job_valid = 1'b0;
        check_eq("to_pre_cleared", preempt_cnt, 0);
        cyc(0); cyc(0); cyc(0);
        check_eq("to_not_yet", wait_timeout, 0);
        cyc(0);
        check_eq("to_set", wait_timeout, 1);
        for (int i = 0; i < 5; i++) cyc(0);
        check_eq("to_sticky", wait_timeout, 1);
        check_eq("to_still_req", req, 1);
        cyc(1); check_eq("to_grant_no_beat", beat_en, 0);
        cyc(1); check_eq("to_beat0", beat_idx, 0);
        cyc(1); check_eq("to_beat1_en", beat_en, 1);
        cyc(1);
        check_eq("to_done", done, 1);
        check_eq("to_done_sticky", wait_timeout, 1);

        // Stale grant: gnt still high when the next job is accepted
        cyc(1);
        job_valid = 1'b1; job_len = 8'd2;
        cyc(1); job_valid = 1'b0;
        check_eq("st_req", req, 1);
        check_eq("st_first_no_beat", beat_en, 0);
        check_eq("st_wt_cleared", wait_timeout, 0);
        cyc(0); check_eq("st_held_low", beat_en, 0);
        cyc(1); check_eq("st_fresh_grant", beat_en, 0);
        cyc(1);
        check_eq("st_beat0_en", beat_en, 1);
        check_eq("st_beat0_idx", beat_idx, 0);
        cyc(1); check_eq("st_beat1_idx", beat_idx, 1);
        cyc(0); check_eq("st_done", done, 1);
        cyc(0);

        // Maximum length job: indices must run 0..254 with no wrap
        job_valid = 1'b1; job_len = 8'd255;
        cyc(0); job_valid = 1'b0;
        cyc(1);
        seq_err = 0;
        for (int i = 0; i < 255; i++) begin
            cyc(1);
            if (!beat_en || (beat_idx != 8'(i))) seq_err++;
        end
        check_eq("max_seq_errors", seq_err, 0);
        cyc(0);
        check_eq("max_done", done, 1);
        check_eq("max_idx", beat_idx, 254);
        cyc(0);

        // Reset mid-XFER at beat 2 of 5
        job_valid = 1'b1; job_len = 8'd5;
        cyc(0); job_valid = 1'b0;
        cyc(1);
        cyc(1); cyc(1); cyc(1);
        check_eq("mr_beat2", beat_idx, 2);
        #1 reset = 1'b1;
        #1;
        check_eq("mr_req_drop", req, 0);
        check_eq("mr_beat_drop", beat_en, 0);
        check_eq("mr_ready_low", job_ready, 0);
        cyc(1); cyc(1);
        reset = 1'b0;
        #1;
        check_eq("mr_idle_ready", job_ready, 1);
        cyc(0);
        check_eq("mr_no_done", done, 0);
        check_eq("mr_no_req", req, 0);
        check_eq("mr_idx_clr", beat_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
